// File: rtl/cm0_pmu_pkg.sv
// Shared definitions for the Cortex-M0 power-management sequencer:
// state encodings, counter width and a saturating increment helper.
package cm0_pmu_pkg;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_WIC_REQ = 2'd1;
  localparam logic [1:0] ST_GATED   = 2'd2;
  localparam logic [1:0] ST_WAKE    = 2'd3;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/cm0_pmu_if.sv
// Core-side handshake bundle between the PMU and the Cortex-M0 integration.
// The master modport is the PMU view; the slave modport is the core view.
interface cm0_pmu_if;

  logic SLEEPING;
  logic SLEEPDEEP;
  logic GATEHCLK;
  logic WAKEUP;
  logic WICENACK;
  logic SLEEPHOLDACKn;
  logic CDBGPWRUPREQ;
  logic WICENREQ;
  logic SLEEPHOLDREQn;
  logic CDBGPWRUPACK;

  modport master (
    input  SLEEPING, SLEEPDEEP, GATEHCLK, WAKEUP, WICENACK, SLEEPHOLDACKn, CDBGPWRUPREQ,
    output WICENREQ, SLEEPHOLDREQn, CDBGPWRUPACK
  );

  modport slave (
    output SLEEPING, SLEEPDEEP, GATEHCLK, WAKEUP, WICENACK, SLEEPHOLDACKn, CDBGPWRUPREQ,
    input  WICENREQ, SLEEPHOLDREQn, CDBGPWRUPACK
  );

endinterface

// File: rtl/cm0_pmu_dly_cnt.sv
// Loadable, clearable, saturating 8-bit counter with terminal-count compare.
// Clear has priority over load, load over increment.
module cm0_pmu_dly_cnt
  import cm0_pmu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic load_i,
  input  cnt_t load_val_i,
  input  cnt_t tc_val_i,
  output logic tc_o
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/cm0_pmu.sv
// Power-management sequencer: sleep/WIC/debug power-up handshakes and the
// HCLK/DCLK gate enable, all on the free-running FCLK domain.
module cm0_pmu
  import cm0_pmu_pkg::*;
#(
  parameter int unsigned WAKE_DLY    = 4,
  parameter int unsigned DBG_DLY     = 2,
  parameter int unsigned WIC_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  cm0_pmu_if.master       pmu_if,
  input  logic            cfg_wic_en_i,
  input  logic            hold_req_i,
  output logic            hold_ack_o,
  output logic            hclken_o,
  output logic [1:0]      pmu_state_o
);

  logic [1:0] state_q, state_d;
  logic       wicenreq_q, wicenreq_d;
  logic       hclken_q;
  logic       sleepholdreqn_q;
  logic       hold_ack_q;
  logic       dbgack_q, dbgack_d;
  logic       st_tc;
  logic       dbg_tc;
  logic       sleeping;
  logic       dbg_req;
  cnt_t       st_tc_val;

  assign sleeping = pmu_if.SLEEPING;
  assign dbg_req  = pmu_if.CDBGPWRUPREQ;

  // WAKE ends after WAKE_DLY cycles; WIC_REQ gives up once the count reaches WIC_TIMEOUT.
  assign st_tc_val = (state_q == ST_WAKE) ? cnt_t'(WAKE_DLY - 1) : cnt_t'(WIC_TIMEOUT);

  cm0_pmu_dly_cnt u_state_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_d != state_q),
    .en_i       (1'b1),
    .load_i     (1'b0),
    .load_val_i ('0),
    .tc_val_i   (st_tc_val),
    .tc_o       (st_tc)
  );

  // Debug counter runs only while the request is held and the ack is not yet given.
  cm0_pmu_dly_cnt u_dbg_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (!dbg_req),
    .en_i       (!dbgack_q),
    .load_i     (1'b0),
    .load_val_i ('0),
    .tc_val_i   (cnt_t'(DBG_DLY)),
    .tc_o       (dbg_tc)
  );

  always_comb begin
    state_d    = state_q;
    wicenreq_d = wicenreq_q;
    case (state_q)
      ST_RUN: begin
        if (sleeping && pmu_if.SLEEPDEEP && cfg_wic_en_i && !dbg_req) begin
          state_d    = ST_WIC_REQ;
          wicenreq_d = 1'b1;
        end else if (sleeping && pmu_if.GATEHCLK && !dbg_req) begin
          state_d = ST_GATED;
        end
      end
      ST_WIC_REQ: begin
        // Abort conditions outrank a simultaneous acknowledge.
        if (!sleeping || pmu_if.WAKEUP || st_tc) begin
          state_d    = ST_RUN;
          wicenreq_d = 1'b0;
        end else if (pmu_if.WICENACK) begin
          state_d = ST_GATED;
        end
      end
      ST_GATED: begin
        if (pmu_if.WAKEUP || dbg_req || (!wicenreq_q && !pmu_if.GATEHCLK)) begin
          state_d = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (st_tc) begin
          state_d    = ST_RUN;
          wicenreq_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign dbgack_d = dbg_req && (dbgack_q || dbg_tc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      wicenreq_q      <= 1'b0;
      hclken_q        <= 1'b1;
      sleepholdreqn_q <= 1'b1;
      hold_ack_q      <= 1'b0;
      dbgack_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      wicenreq_q      <= wicenreq_d;
      hclken_q        <= (state_d != ST_GATED);
      sleepholdreqn_q <= !(hold_req_i && sleeping);
      hold_ack_q      <= !pmu_if.SLEEPHOLDACKn && hold_req_i && sleeping;
      dbgack_q        <= dbgack_d;
    end
  end

  assign pmu_if.WICENREQ      = wicenreq_q;
  assign pmu_if.SLEEPHOLDREQn = sleepholdreqn_q;
  assign pmu_if.CDBGPWRUPACK  = dbgack_q;
  assign hold_ack_o           = hold_ack_q;
  assign hclken_o             = hclken_q;
  assign pmu_state_o          = state_q;

endmodule
